// File: rtl/fpga_status_pkg.sv
// Shared types for the board status LED controller.
// LED channel modes, exit FSM states and blink-code gap length.
package fpga_status_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'b00,
        LED_ON      = 2'b01,
        LED_BLINK   = 2'b10,
        LED_STRETCH = 2'b11
    } led_mode_e;

    typedef enum logic [2:0] {
        EX_IDLE     = 3'd0,
        EX_PASS     = 3'd1,
        EX_FAIL_ON  = 3'd2,
        EX_FAIL_OFF = 3'd3,
        EX_FAIL_GAP = 3'd4
    } exit_state_e;

    localparam int unsigned GAP_TICKS = 4;

endpackage

// File: rtl/fpga_led_channel.sv
// One moded LED channel: PWM compare, blink flop and event stretcher.
// The output is registered so mode/duty changes show after one edge.
module fpga_led_channel
    import fpga_status_pkg::*;
#(
    parameter int PWM_WIDTH      = 8,
    parameter int STRETCH_CYCLES = 2**20
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           mode_i,
    input  logic [PWM_WIDTH-1:0] duty_i,
    input  logic [PWM_WIDTH-1:0] pwm_cnt_i,
    input  logic                 event_i,
    input  logic                 tick_i,
    output logic                 led_o
);

    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] RELOAD = SW'(STRETCH_CYCLES - 1);
    localparam logic [SW-1:0] ONE    = SW'(1);

    led_mode_e       mode;
    logic            pwm_on;
    logic            blink_q, blink_d;
    logic            led_q, led_d;
    logic [SW-1:0]   scnt_q, scnt_d;

    assign mode = led_mode_e'(mode_i);

    always_comb begin
        pwm_on  = (duty_i == '1) || (pwm_cnt_i < duty_i);
        blink_d = 1'b0;
        if (mode == LED_BLINK) begin
            blink_d = blink_q ^ tick_i;
        end
        // The stretcher runs in every mode so a late switch shows the tail.
        scnt_d = scnt_q;
        if (event_i) begin
            scnt_d = RELOAD;
        end else if (scnt_q != '0) begin
            scnt_d = scnt_q - ONE;
        end
        led_d = 1'b0;
        unique case (mode)
            LED_OFF:     led_d = 1'b0;
            LED_ON:      led_d = pwm_on;
            LED_BLINK:   led_d = blink_d;
            LED_STRETCH: led_d = event_i | (scnt_q != '0);
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_q <= 1'b0;
            scnt_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            blink_q <= blink_d;
            scnt_q  <= scnt_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/fpga_status_led_ctrl.sv
// Board status indicator: heartbeat prescaler, moded LED channels
// and an exit FSM that shows pass solid and fail as a blink code.
module fpga_status_led_ctrl
    import fpga_status_pkg::*;
#(
    parameter int NUM_LEDS        = 4,
    parameter int PRESCALER_WIDTH = 27,
    parameter int TICK_BIT        = 22,
    parameter int PWM_WIDTH       = 8,
    parameter int STRETCH_CYCLES  = 2**20
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [2*NUM_LEDS-1:0]         led_mode_i,
    input  logic [PWM_WIDTH*NUM_LEDS-1:0] led_duty_i,
    input  logic [NUM_LEDS-1:0]           event_i,
    input  logic                          exit_valid_i,
    input  logic [31:0]                   exit_value_i,
    output logic                          heartbeat_o,
    output logic [NUM_LEDS-1:0]           led_o,
    output logic                          exit_led_o,
    output logic                          exit_fail_o
);

    logic [PRESCALER_WIDTH-1:0] cnt_q;
    logic                       tick;
    logic [PWM_WIDTH-1:0]       pwm_cnt;

    assign tick        = &cnt_q[TICK_BIT-1:0];
    assign pwm_cnt     = cnt_q[PWM_WIDTH-1:0];
    assign heartbeat_o = cnt_q[PRESCALER_WIDTH-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESCALER_WIDTH'(1);
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        fpga_led_channel #(
            .PWM_WIDTH      (PWM_WIDTH),
            .STRETCH_CYCLES (STRETCH_CYCLES)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .mode_i    (led_mode_i[2*i +: 2]),
            .duty_i    (led_duty_i[PWM_WIDTH*i +: PWM_WIDTH]),
            .pwm_cnt_i (pwm_cnt),
            .event_i   (event_i[i]),
            .tick_i    (tick),
            .led_o     (led_o[i])
        );
    end

    exit_state_e state_q, state_d;
    logic [4:0]  nblink_q, nblink_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic [2:0]  gcnt_q, gcnt_d;
    logic        exit_led_q, exit_led_d;
    logic        fail_q, fail_d;

    always_comb begin
        state_d    = state_q;
        nblink_d   = nblink_q;
        bcnt_d     = bcnt_q;
        gcnt_d     = gcnt_q;
        fail_d     = fail_q;
        exit_led_d = 1'b0;
        unique case (state_q)
            EX_IDLE: begin
                if (exit_valid_i) begin
                    if (exit_value_i == 32'd0) begin
                        state_d = EX_PASS;
                    end else begin
                        state_d  = EX_FAIL_ON;
                        nblink_d = (exit_value_i[3:0] == 4'd0) ? 5'd16
                                 : {1'b0, exit_value_i[3:0]};
                        bcnt_d   = 5'd0;
                        fail_d   = 1'b1;
                    end
                end
            end
            EX_PASS: begin
            end
            EX_FAIL_ON: begin
                if (tick) begin
                    state_d = EX_FAIL_OFF;
                    bcnt_d  = bcnt_q + 5'd1;
                end
            end
            EX_FAIL_OFF: begin
                if (tick) begin
                    if (bcnt_q == nblink_q) begin
                        state_d = EX_FAIL_GAP;
                        gcnt_d  = 3'd0;
                    end else begin
                        state_d = EX_FAIL_ON;
                    end
                end
            end
            EX_FAIL_GAP: begin
                if (tick) begin
                    if (gcnt_q == 3'(GAP_TICKS - 1)) begin
                        state_d = EX_FAIL_ON;
                        bcnt_d  = 5'd0;
                    end else begin
                        gcnt_d = gcnt_q + 3'd1;
                    end
                end
            end
            default: state_d = EX_IDLE;
        endcase
        // Drive the LED from the next state so each phase is tick-aligned.
        if (state_d == EX_IDLE) begin
            exit_led_d = heartbeat_o;
        end else if (state_d == EX_PASS || state_d == EX_FAIL_ON) begin
            exit_led_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EX_IDLE;
            nblink_q   <= 5'd0;
            bcnt_q     <= 5'd0;
            gcnt_q     <= 3'd0;
            exit_led_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nblink_q   <= nblink_d;
            bcnt_q     <= bcnt_d;
            gcnt_q     <= gcnt_d;
            exit_led_q <= exit_led_d;
            fail_q     <= fail_d;
        end
    end

    assign exit_led_o  = exit_led_q;
    assign exit_fail_o = fail_q;

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Bench for fpga_status_led_ctrl: table-driven PWM vectors, directed
// corner sequences and random stimulus against a behavioural model.
module tb_fpga_status_led_ctrl;

    localparam int NL = 4;
    localparam int PW = 8;
    localparam int TB = 3;
    localparam int WW = 4;
    localparam int SC = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [2*NL-1:0]   mode;
    logic [WW*NL-1:0]  duty;
    logic [NL-1:0]     ev;
    logic              xv;
    logic [31:0]       xval;
    logic              hb;
    logic [NL-1:0]     led;
    logic              xled;
    logic              xfail;

    fpga_status_led_ctrl #(
        .NUM_LEDS        (NL),
        .PRESCALER_WIDTH (PW),
        .TICK_BIT        (TB),
        .PWM_WIDTH       (WW),
        .STRETCH_CYCLES  (SC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .led_mode_i   (mode),
        .led_duty_i   (duty),
        .event_i      (ev),
        .exit_valid_i (xv),
        .exit_value_i (xval),
        .heartbeat_o  (hb),
        .led_o        (led),
        .exit_led_o   (xled),
        .exit_fail_o  (xfail)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset, per-channel blink phase and
    // last event edge, exit mode (0 idle, 1 pass, 2 fail) and ticks.
    int          e;
    int          ph [NL];
    int          last_ev [NL];
    logic [NL-1:0] exp_led;
    int          xm;
    int          xn;
    int          xt;
    logic        exp_xled;
    logic        exp_xfail;

    typedef struct {
        logic [1:0] m;
        logic [3:0] d;
        int         hi;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0;
        for (int i = 0; i < NL; i++) begin
            ph[i] = 0;
            last_ev[i] = -1000;
        end
        exp_led   = '0;
        xm        = 0;
        xn        = 0;
        xt        = 0;
        exp_xled  = 1'b0;
        exp_xfail = 1'b0;
    endtask

    task automatic model_edge();
        int pre;
        bit tk;
        int grp;
        pre = e % 256;
        tk  = (pre % 8) == 7;
        for (int i = 0; i < NL; i++) begin
            int m;
            int d;
            m = int'(mode[2*i +: 2]);
            d = int'(duty[4*i +: 4]);
            if (m == 2) begin
                if (tk) ph[i] = ph[i] ^ 1;
            end else begin
                ph[i] = 0;
            end
            if (ev[i]) last_ev[i] = e;
            case (m)
                0: exp_led[i] = 1'b0;
                1: exp_led[i] = (d == 15) || ((pre % 16) < d);
                2: exp_led[i] = ph[i][0];
                default: exp_led[i] = (e - last_ev[i]) < SC;
            endcase
        end
        if (xm == 0) begin
            if (xv) begin
                if (xval == 32'd0) begin
                    xm = 1;
                end else begin
                    xm = 2;
                    xn = (xval[3:0] == 4'd0) ? 16 : int'(xval[3:0]);
                    xt = 0;
                    exp_xfail = 1'b1;
                end
            end
        end else if (xm == 2 && tk) begin
            xt++;
        end
        grp = 2 * xn + 4;
        if (xm == 0)      exp_xled = pre >= 128;
        else if (xm == 1) exp_xled = 1'b1;
        else              exp_xled = ((xt % grp) < 2 * xn) && ((xt % 2) == 0);
        e++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("heartbeat", int'(hb), int'((e % 256) >= 128));
        chk("led", int'(led), int'(exp_led));
        chk("exit_led", int'(xled), int'(exp_xled));
        chk("exit_fail", int'(xfail), int'(exp_xfail));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async_hb", int'(hb), 0);
        chk("rst_async_led", int'(led), 0);
        chk("rst_async_xled", int'(xled), 0);
        chk("rst_async_xfail", int'(xfail), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int hi;
        mode = '0;
        duty = '0;
        ev   = '0;
        xv   = 1'b0;
        xval = '0;
        vecs[0] = '{2'd1, 4'd4, 4};
        vecs[1] = '{2'd1, 4'd15, 16};
        vecs[2] = '{2'd1, 4'd0, 0};
        vecs[3] = '{2'd1, 4'd9, 9};
        vecs[4] = '{2'd1, 4'd1, 1};
        vecs[5] = '{2'd0, 4'd7, 0};
        vecs[6] = '{2'd3, 4'd3, 0};
        vecs[7] = '{2'd1, 4'd14, 14};
        model_reset();
        #2;
        do_reset();

        repeat (127) step();
        chk("hb_before_128", int'(hb), 0);
        step();
        chk("hb_at_128", int'(hb), 1);
        repeat (127) step();
        chk("hb_hold", int'(hb), 1);
        step();
        chk("hb_fall_256", int'(hb), 0);

        for (int v = 0; v < 8; v++) begin
            mode[1:0] = vecs[v].m;
            duty[3:0] = vecs[v].d;
            step();
            hi = 0;
            for (int k = 0; k < 16; k++) begin
                step();
                hi += int'(led[0]);
            end
            chk($sformatf("pwm_tbl%0d", v), hi, vecs[v].hi);
        end
        mode[1:0] = 2'd1;
        duty[3:0] = 4'd15;
        step();
        chk("duty15_now", int'(led[0]), 1);
        duty[3:0] = 4'd0;
        step();
        chk("duty0_next_edge", int'(led[0]), 0);
        mode[1:0] = 2'd0;

        mode[3:2] = 2'd2;
        repeat (30) step();
        mode[3:2] = 2'd0;
        repeat (3) step();
        chk("blink_off_dark", int'(led[1]), 0);
        mode[3:2] = 2'd2;
        repeat (20) step();

        mode[5:4] = 2'd3;
        step();
        ev[2] = 1'b1;
        step();
        hi = int'(led[2]);
        ev[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            hi += int'(led[2]);
        end
        chk("stretch_single", hi, 5);
        ev[2] = 1'b1;
        step();
        hi = int'(led[2]);
        ev[2] = 1'b0;
        repeat (2) begin
            step();
            hi += int'(led[2]);
        end
        ev[2] = 1'b1;
        step();
        hi += int'(led[2]);
        ev[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            hi += int'(led[2]);
        end
        chk("stretch_retrig", hi, 8);
        ev[3] = 1'b1;
        step();
        ev[3] = 1'b0;
        step();
        mode[7:6] = 2'd3;
        step();
        chk("stretch_carry", int'(led[3]), 1);
        repeat (6) step();

        xv = 1'b1;
        xval = 32'd0;
        step();
        xv = 1'b0;
        repeat (20) step();
        xv = 1'b1;
        xval = 32'd3;
        step();
        xv = 1'b0;
        repeat (20) step();
        chk("pass_led", int'(xled), 1);
        chk("pass_nofail", int'(xfail), 0);

        do_reset();
        xv = 1'b1;
        xval = 32'h12;
        step();
        xv = 1'b0;
        repeat (100) step();
        hi = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            hi += int'(xled);
        end
        chk("fail12_group_on", hi, 16);
        for (int k = 0; k < 80 && !xled; k++) step();
        chk("fail_on_reached", int'(xled), 1);
        do_reset();
        step();
        chk("after_rst_idle_fail", int'(xfail), 0);

        xv = 1'b1;
        xval = 32'h10;
        step();
        xv = 1'b0;
        repeat (300) step();
        hi = 0;
        for (int k = 0; k < 288; k++) begin
            step();
            hi += int'(xled);
        end
        chk("fail10_group_on", hi, 128);

        do_reset();
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 19) == 0) mode[2*i +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) duty[4*i +: 4] = 4'($urandom_range(0, 15));
                ev[i] = ($urandom_range(0, 9) == 0);
            end
            xv = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 3))
                0: xval = 32'd0;
                1: xval = {$urandom_range(0, 255), 4'd0};
                default: xval = $urandom;
            endcase
            if (k == 2000) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
